// File: rtl/seq_vec_mat_mult.sv
// Sequential vector-by-matrix multiplier: result[j] = sum_i multiply(vec[i], mat[i][j]) using LANES shared multipliers.
// Define VMM_EMIT_SCALE_EN to build the emit port and the fused per-state emission SCALE stage.
package vmm_defs;
    localparam int HIDDEN_STATES = 4;
    localparam int DATA_PREC     = 8;
endpackage

module seq_vec_mat_mult
    import vmm_defs::*;
#(
    parameter int N     = HIDDEN_STATES,
    parameter int W     = DATA_PREC,
    parameter int LANES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0][W-1:0]        vec,
    input  logic [N-1:0][N-1:0][W-1:0] mat,
`ifdef VMM_EMIT_SCALE_EN
    input  logic [N-1:0][W-1:0]        emit,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0][W-1:0]        result,
    output logic                       busy
);

    localparam int LANES_SAFE = (LANES < 1) ? 1 : LANES;
    localparam int GROUPS     = N / LANES_SAFE;
    localparam int RW         = (N > 1) ? $clog2(N) : 1;
    localparam int GW         = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);

    if (LANES < 1 || LANES > N || (N % LANES_SAFE) != 0) begin : g_bad_lanes
        $error("seq_vec_mat_mult: LANES must satisfy 1 <= LANES <= N and N %% LANES == 0");
    end

    // Unsigned fixed point with W-1 fraction bits (ONE = 2^(W-1)); product truncated to W bits.
    function automatic logic [W-1:0] multiply(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] w_full;
        w_full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return w_full[W-1 +: W];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SCALE,
        S_DONE
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic [N-1:0][W-1:0]          r_vec;
    logic [N-1:0][N-1:0][W-1:0]   r_mat;
    logic [N-1:0][W-1:0]          r_acc;
    logic [RW-1:0]                r_row;
    logic [GW-1:0]                r_grp;
    logic [RW-1:0]                w_col [LANES_SAFE];
    logic                         w_accept;
    logic                         w_row_last;
    logic                         w_grp_last;
`ifdef VMM_EMIT_SCALE_EN
    logic [N-1:0][W-1:0]          r_emit;
`endif

    for (genvar l = 0; l < LANES_SAFE; l++) begin : g_col
        assign w_col[l] = RW'(int'(r_grp) * LANES_SAFE + l);
    end

    assign w_accept   = in_valid && in_ready;
    assign w_row_last = (r_row == ROW_LAST);
    assign w_grp_last = (r_grp == GRP_LAST);
    assign result     = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = !rst;
                if (w_accept) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_row_last && w_grp_last) begin
`ifdef VMM_EMIT_SCALE_EN
                    w_next_state = S_SCALE;
`else
                    w_next_state = S_DONE;
`endif
                end
            end
            S_SCALE: begin
                busy = 1'b1;
                if (w_grp_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand and accumulator arrays are plain flops, cleared so result reads 0 right after reset.
            r_vec <= '0;
            r_mat <= '0;
            r_acc <= '0;
            r_row <= '0;
            r_grp <= '0;
`ifdef VMM_EMIT_SCALE_EN
            r_emit <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_vec <= vec;
                        r_mat <= mat;
                        r_acc <= '0;
                        r_row <= '0;
                        r_grp <= '0;
`ifdef VMM_EMIT_SCALE_EN
                        r_emit <= emit;
`endif
                    end
                end
                S_RUN: begin
                    // NOTE: non-blocking updates; each lane reads the accumulator value from before this edge.
                    for (int l = 0; l < LANES_SAFE; l++) begin
                        r_acc[w_col[l]] <= r_acc[w_col[l]] + multiply(r_vec[r_row], r_mat[r_row][w_col[l]]);
                    end
                    if (w_row_last) begin
                        r_row <= '0;
                        r_grp <= w_grp_last ? '0 : r_grp + GW'(1);
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
`ifdef VMM_EMIT_SCALE_EN
                S_SCALE: begin
                    for (int l = 0; l < LANES_SAFE; l++) begin
                        r_acc[w_col[l]] <= multiply(r_acc[w_col[l]], r_emit[w_col[l]]);
                    end
                    r_grp <= w_grp_last ? '0 : r_grp + GW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_vec_mat_mult.sv
// Scoreboard bench for seq_vec_mat_mult: three instances (LANES=1,2,4) share stimulus; per-instance monitors check result, latency and busy time.
// Honours VMM_EMIT_SCALE_EN when defined.
module tb_seq_vec_mat_mult;

    typedef logic [3:0][7:0]      vec_t;
    typedef logic [3:0][3:0][7:0] mat_t;

    localparam logic [7:0] ONE = 8'h80;

    logic clk;
    logic rst;
    logic in_valid;
    logic out_ready;
    vec_t vec_in;
    mat_t mat_in;
    vec_t emit_in;

    int err_cnt = 0;
    int chk_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
`ifdef VMM_EMIT_SCALE_EN
        localparam int LAT = 16 / L + 4 / L + 1;
`else
        localparam int LAT = 16 / L + 1;
`endif
        logic in_ready;
        logic out_valid;
        logic busy;
        vec_t result;
        vec_t exp_q[$];

        seq_vec_mat_mult #(.N(4), .W(8), .LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .vec       (vec_in),
            .mat       (mat_in),
`ifdef VMM_EMIT_SCALE_EN
            .emit      (emit_in),
`endif
            .out_valid (out_valid),
            .out_ready (out_ready),
            .result    (result),
            .busy      (busy)
        );

        initial begin : monitor
            bit   armed;
            int   cnt;
            int   busy_cnt;
            vec_t exp;
            armed = 1'b0;
            cnt = 0;
            busy_cnt = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    armed = 1'b0;
                end else begin
                    if (armed) begin
                        cnt++;
                        if (busy) busy_cnt++;
                        if (out_valid) begin
                            armed = 1'b0;
                            check($sformatf("latency L%0d", L), cnt, LAT);
                            check($sformatf("busy_cycles L%0d", L), busy_cnt, LAT - 1);
                        end else if (cnt > 300) begin
                            armed = 1'b0;
                            chk_cnt++;
                            err_cnt++;
                            $display("FAIL timeout L%0d: no out_valid after %0d cycles, required %0d", L, cnt, LAT);
                        end
                    end
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk_cnt++;
                            err_cnt++;
                            $display("FAIL unexpected_output L%0d: got %0h, required no output", L, result);
                        end else begin
                            exp = exp_q.pop_front();
                            check($sformatf("result L%0d", L), result, exp);
                        end
                    end
                    if (in_valid && in_ready) begin
                        armed = 1'b1;
                        cnt = 0;
                        busy_cnt = 0;
                    end
                end
            end
        end
    end

    function automatic logic [7:0] mul8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, a} * {8'd0, b};
        return p[14:7];
    endfunction

    function automatic vec_t model(input vec_t v, input mat_t m, input vec_t e);
        vec_t r;
        for (int j = 0; j < 4; j++) begin
            logic [7:0] s;
            s = 8'd0;
            for (int i = 0; i < 4; i++) s = s + mul8(v[i], m[i][j]);
`ifdef VMM_EMIT_SCALE_EN
            s = mul8(s, e[j]);
`endif
            r[j] = s;
        end
        return r;
    endfunction

    function automatic logic all_ready();
        return g_dut[0].in_ready && g_dut[1].in_ready && g_dut[2].in_ready;
    endfunction

    function automatic int pending();
        return g_dut[0].exp_q.size() + g_dut[1].exp_q.size() + g_dut[2].exp_q.size();
    endfunction

    task automatic push_all(input vec_t e);
        g_dut[0].exp_q.push_back(e);
        g_dut[1].exp_q.push_back(e);
        g_dut[2].exp_q.push_back(e);
    endtask

    task automatic flush_all();
        g_dut[0].exp_q.delete();
        g_dut[1].exp_q.delete();
        g_dut[2].exp_q.delete();
    endtask

    // Called just after a rising edge; drives one accepted transaction to all three instances.
    task automatic send(input vec_t v, input mat_t m, input vec_t e, input vec_t exp);
        int waited;
        waited = 0;
        while (!all_ready() && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!all_ready()) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL send_wait: in_ready low for %0d cycles, required 1", waited);
        end else begin
            vec_in   = v;
            mat_in   = m;
            emit_in  = e;
            in_valid = 1'b1;
            push_all(exp);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (pending() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (pending() != 0) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL drain: %0d results outstanding, required 0", pending());
        end
    endtask

    function automatic mat_t identity();
        mat_t m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i][i] = ONE;
        return m;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 4; i++) v[i] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < 4; i++) m[i] = rand_vec();
        return m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        mat_t m;
        vec_t e;
        vec_t ones;
        vec_t exp;
        vec_t exp_hold;
        int   t;

        void'($urandom(32'd20240611));
        ones     = {4{ONE}};
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        vec_in   = '0;
        mat_in   = '0;
        emit_in  = ones;

        // Reset state
        @(posedge clk);
        #1;
        check("reset in_ready", g_dut[0].in_ready, 1'b0);
        check("reset out_valid", g_dut[0].out_valid, 1'b0);
        check("reset busy", g_dut[0].busy, 1'b0);
        check("reset result", g_dut[0].result, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle in_ready", g_dut[0].in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Identity: vec = {ONE,0,0,0}
        v = '0;
        v[0] = ONE;
        exp = '0;
        exp[0] = ONE;
        send(v, identity(), ones, exp);

        // vec all ONE, mat[i][j] = 16*(i+1)+j: column sums 0xA0 + 4j
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) m[i][j] = 8'(16 * (i + 1) + j);
        send(ones, m, ones, {8'hAC, 8'hA8, 8'hA4, 8'hA0});

        // Seeded random operands against the model
        for (int n = 0; n < 3; n++) begin
            v = rand_vec();
            m = rand_mat();
            send(v, m, ones, model(v, m, ones));
        end

        // Wraparound: every product is 0x80, four of them sum to 0x200 -> 0x00
        m = '0;
        for (int i = 0; i < 4; i++) m[i] = ones;
        send(ones, m, ones, 32'h0);
        drain();

        // Backpressure: hold out_ready low for 10 cycles with out_valid up
        out_ready = 1'b0;
        v = rand_vec();
        m = rand_mat();
        exp_hold = model(v, m, ones);
        send(v, m, ones, exp_hold);
        t = 0;
        while (!g_dut[0].out_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp out_valid arrives", g_dut[0].out_valid, 1'b1);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            vec_in   = rand_vec();
            mat_in   = rand_mat();
            @(negedge clk);
            check("bp out_valid held", g_dut[0].out_valid, 1'b1);
            check("bp result stable", g_dut[0].result, exp_hold);
            check("bp in_ready low", g_dut[0].in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp out_valid dropped", g_dut[0].out_valid, 1'b0);
        check("bp in_ready back", g_dut[0].in_ready, 1'b1);
        v = rand_vec();
        m = rand_mat();
        send(v, m, ones, model(v, m, ones));
        drain();

        // Reset on cycle 5 of RUN
        v = rand_vec();
        m = rand_mat();
        send(v, m, ones, model(v, m, ones));
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("mid-run busy before reset", g_dut[0].busy, 1'b1);
        rst = 1'b1;
        flush_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort out_valid", g_dut[0].out_valid, 1'b0);
        check("abort busy", g_dut[0].busy, 1'b0);
        check("abort result", g_dut[0].result, 32'h0);
        check("abort in_ready", g_dut[0].in_ready, 1'b1);
        check("abort result L4", g_dut[2].result, 32'h0);
        @(posedge clk);
        #1;
        v = rand_vec();
        m = rand_mat();
        send(v, m, ones, model(v, m, ones));
        drain();

        // vec all ONE, mat identity, emit {ONE,0,ONE,0}
        e = '0;
        e[0] = ONE;
        e[2] = ONE;
`ifdef VMM_EMIT_SCALE_EN
        exp = e;
`else
        exp = ones;
`endif
        send(ones, identity(), e, exp);
        drain();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
